// File: rtl/fetch_pkg.sv
// Fetch stage shared types and constants.
// State encodings, BEQ opcode and the NOP word.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ     = 2'd0,
    FETCH_DISCARD = 2'd1,
    FETCH_STALL   = 2'd2
  } fetch_state_e;

  localparam logic [5:0]  OPCODE_BEQ = 6'h04;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

endpackage

// File: rtl/fetch_branch_target.sv
// PC-relative branch target: pc + 4 + (sext(imm16) << 2).
// Purely combinational; wraps modulo 2^32.
module branch_target (
  input  logic [31:0] pc_i,
  input  logic [15:0] imm16_i,
  output logic [31:0] target_o
);

  logic [31:0] off;

  // Word offset, sign-extended and scaled to bytes
  always_comb begin
    off      = {{14{imm16_i[15]}}, imm16_i, 2'b00};
    target_o = pc_i + 32'd4 + off;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, one outstanding
// imem request, an output slot and a one-entry skid.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump
);

  fetch_state_e state_q, state_d;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redir_q, redir_d;
  slot_t       out_q, out_d;
  slot_t       skid_q, skid_d;
  logic        valid_q, valid_d;

  logic        accept, taken, slot_free;
  logic [31:0] tgt;

  assign accept    = valid_q & instr_ready;
  assign taken     = accept & jump;
  assign slot_free = ~valid_q | (accept & ~jump);

  branch_target u_bt (
    .pc_i    (out_q.pc),
    .imm16_i (out_q.instr[15:0]),
    .target_o(tgt)
  );

  assign imem_addr   = fetch_pc_q;
  assign instr       = out_q.instr;
  assign instr_pc    = out_q.pc;
  assign instr_valid = valid_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_REQ;
    else     state_q <= state_d;
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_REQ: begin
        if (imem_ack) begin
          if (!taken && !slot_free)
            state_d = FETCH_STALL;
        end else if (taken) begin
          state_d = FETCH_DISCARD;
        end
      end
      FETCH_DISCARD: begin
        if (imem_ack) state_d = FETCH_REQ;
      end
      FETCH_STALL: begin
        if (accept) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  // Request line and datapath next values
  always_comb begin
    imem_req   = (state_q != FETCH_STALL);
    fetch_pc_d = fetch_pc_q;
    redir_d    = redir_q;
    out_d      = out_q;
    skid_d     = skid_q;
    valid_d    = valid_q;
    unique case (state_q)
      FETCH_REQ: begin
        if (imem_ack) begin
          if (taken) begin
            valid_d    = 1'b0;
            fetch_pc_d = tgt;
          end else if (slot_free) begin
            out_d.instr = imem_data;
            out_d.pc    = fetch_pc_q;
            valid_d     = 1'b1;
            fetch_pc_d  = fetch_pc_q + 32'd4;
          end else begin
            skid_d.instr = imem_data;
            skid_d.pc    = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + 32'd4;
          end
        end else if (taken) begin
          redir_d = tgt;
          valid_d = 1'b0;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      FETCH_DISCARD: begin
        if (imem_ack) fetch_pc_d = redir_q;
      end
      FETCH_STALL: begin
        if (taken) begin
          fetch_pc_d = tgt;
          valid_d    = 1'b0;
        end else if (accept) begin
          out_d = skid_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      redir_q    <= '0;
      out_q      <= '{instr: NOP, pc: 32'h0};
      skid_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      redir_q    <= redir_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      valid_q    <= valid_d;
    end
  end

`ifndef SYNTHESIS
  logic        chk_hold_q;
  logic [31:0] chk_addr_q;

  // Pending request must keep its address until acked
  always_ff @(posedge clk) begin
    if (rst) chk_hold_q <= 1'b0;
    else     chk_hold_q <= imem_req & ~imem_ack;
    chk_addr_q <= imem_addr;
    if (!rst && chk_hold_q && imem_req)
      assert (imem_addr == chk_addr_q)
      else $error("imem_addr moved while request pending");
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for the fetch stage.
// Memory model with tunable latency and small programs.
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;

  int          lat;
  int          mode;
  int          wcnt;
  int          ack_cnt;
  logic [31:0] jump_at;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump       (jump)
  );

  function automatic logic [31:0] tag(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic logic [31:0] mem_word(
    input logic [31:0] a, input int m);
    logic [31:0] w;
    w = tag(a);
    if (m == 1 && a == 32'h10) w = {OPCODE_BEQ, 10'd0, 16'h0003};
    if (m == 2 && a == 32'h40) w = {OPCODE_BEQ, 10'd0, 16'hFFFC};
    if (m == 3 && a == 32'h00) w = {OPCODE_BEQ, 10'd0, 16'hFFFE};
    if (m == 4 && a == 32'h00) w = {OPCODE_BEQ, 10'd0, 16'h0003};
    return w;
  endfunction

  assign imem_ack  = imem_req && (wcnt >= lat);
  assign imem_data = imem_ack ? mem_word(imem_addr, mode)
                              : 32'hDEAD_BEEF;
  assign jump      = instr_valid && (instr_pc == jump_at);

  always @(posedge clk) begin
    if (rst) begin
      wcnt    <= 0;
      ack_cnt <= 0;
    end else if (imem_ack) begin
      wcnt    <= 0;
      ack_cnt <= ack_cnt + 1;
    end else if (imem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    q.push_back(e);
  endtask

  task automatic push_run(input logic [31:0] a0, input int n);
    for (int i = 0; i < n; i++)
      push(a0 + 32'(4 * i), tag(a0 + 32'(4 * i)));
  endtask

  // Monitor: every accepted instruction must be the next expected
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected: pc %h instr %h", instr_pc, instr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out pc", instr_pc, e.pc);
        chk("out instr", instr, e.ins);
      end
    end
  end

  task automatic reset1();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string nm, input int exp_c,
                       input int probe_c, input logic [31:0] probe_a);
    int c;
    c = 0;
    while (1) begin
      @(posedge clk); #1;
      c++;
      if (c == probe_c) chk({nm, " addr"}, imem_addr, probe_a);
      if (q.size() == 0) break;
      if (c >= 80) begin
        n_total++;
        $display("FAIL %s timeout: got %0d left expected 0", nm, q.size());
        q.delete();
        break;
      end
    end
    instr_ready = 1'b0;
    if (exp_c > 0) chk({nm, " cycles"}, 32'(c), 32'(exp_c));
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0;
    lat = 0; mode = 0; jump_at = 32'h1;

    // Reset + streaming
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", {31'd0, instr_valid}, 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst pc", instr_pc, 32'h0);
    chk("rst req", {31'd0, imem_req}, 32'd1);
    chk("rst addr", imem_addr, 32'h0);
    chk("rst state", 32'(dut.state_q), 32'(FETCH_REQ));
    push_run(32'h0, 8);
    instr_ready = 1'b1;
    rst = 1'b0;
    drain("stream", 9, 1, 32'h4);

    // Backpressure: one skid capture, no request in STALL
    reset1();
    push_run(32'h0, 3);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 2) chk("bp state", 32'(dut.state_q), 32'(FETCH_STALL));
      if (i >= 2) begin
        chk("bp req", {31'd0, imem_req}, 32'd0);
        chk("bp hold pc", instr_pc, 32'h0);
        chk("bp hold ins", instr, tag(32'h0));
      end
    end
    chk("bp acks", 32'(ack_cnt), 32'd2);
    instr_ready = 1'b1;
    drain("bp", 3, 0, 32'h0);

    // Taken forward BEQ at 0x10
    mode = 1; jump_at = 32'h10;
    reset1();
    push_run(32'h0, 4);
    push(32'h10, 32'h1000_0003);
    push_run(32'h20, 2);
    instr_ready = 1'b1;
    drain("beq fwd", 9, 6, 32'h20);

    // Backward BEQ at 0x40
    mode = 2; jump_at = 32'h40;
    reset1();
    push_run(32'h0, 16);
    push(32'h40, 32'h1000_FFFC);
    push_run(32'h34, 3);
    instr_ready = 1'b1;
    drain("beq back", 22, 18, 32'h34);

    // Wrap below zero
    mode = 3; jump_at = 32'h0;
    reset1();
    push(32'h0, 32'h1000_FFFE);
    push(32'hFFFF_FFFC, tag(32'hFFFF_FFFC));
    instr_ready = 1'b1;
    drain("beq wrap", 4, 2, 32'hFFFF_FFFC);

    // Redirect while a 3-cycle fetch is outstanding
    mode = 4; jump_at = 32'h0; lat = 3;
    reset1();
    push(32'h0, 32'h1000_0003);
    push(32'h10, tag(32'h10));
    instr_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        chk("dis state", 32'(dut.state_q), 32'(FETCH_DISCARD));
        chk("dis req", {31'd0, imem_req}, 32'd1);
        chk("dis addr", imem_addr, 32'h4);
        chk("dis valid", {31'd0, instr_valid}, 32'd0);
      end
      if (c == 7) begin
        chk("dis hold addr", imem_addr, 32'h4);
        chk("dis hold valid", {31'd0, instr_valid}, 32'd0);
      end
      if (c == 8) begin
        chk("dis exit", 32'(dut.state_q), 32'(FETCH_REQ));
        chk("dis tgt addr", imem_addr, 32'h10);
      end
      if (c > 8 && q.size() == 0) break;
      if (c == 40) begin
        n_total++;
        $display("FAIL dis timeout: got %0d left expected 0", q.size());
        q.delete();
      end
    end
    instr_ready = 1'b0;

    // Reset while in DISCARD
    reset1();
    push(32'h0, 32'h1000_0003);
    instr_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid dis state", 32'(dut.state_q), 32'(FETCH_DISCARD));
    q.delete();
    instr_ready = 1'b0;
    reset1();
    chk("rdis valid", {31'd0, instr_valid}, 32'd0);
    chk("rdis req", {31'd0, imem_req}, 32'd1);
    chk("rdis addr", imem_addr, 32'h0);
    chk("rdis state", 32'(dut.state_q), 32'(FETCH_REQ));

    // Reset while in STALL
    lat = 0; mode = 0; jump_at = 32'h1;
    reset1();
    repeat (3) @(posedge clk);
    #1;
    chk("mid stall state", 32'(dut.state_q), 32'(FETCH_STALL));
    reset1();
    chk("rstl valid", {31'd0, instr_valid}, 32'd0);
    chk("rstl req", {31'd0, imem_req}, 32'd1);
    chk("rstl addr", imem_addr, 32'h0);
    chk("rstl pc", instr_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
